mul_pair_issuer: RTL and testbench
==================================

MUL_PAIR_ISSUER -- requirements
Module: mul_pair_issuer

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles in WAIT before abort.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  block accepts pair this cycle.
REQ-006 in_op1, in_op2  input  32 each  IEEE754 single operands.
REQ-007 in_last  input  1  pair closes job; odd tail.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_res  output  32  product.
REQ-011 out_last  output  1  final result of an in_last job.
REQ-012 mul_ready  output  1  start pulse to dual multiplier.
REQ-013 mul_op1, mul_op2  output  32 each  operands to dual multiplier.
REQ-014 mul_res  input  32  multiplier result.
REQ-015 mul_done  input  1  multiplier done flag.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  sticky abort flag.

Function
REQ-018 States SHALL be IDLE, REQ, SEND_A, SEND_B, WAIT, CAPB, OUT.
REQ-019 IDLE: in_ready=1 while fewer than 2 pairs buffered; handshake on in_valid&in_ready; first pair -> slot A, second -> slot B.
REQ-020 IDLE -> REQ when slot B filled, or slot A filled with in_last=1; in_last of that pair recorded.
REQ-021 Odd tail: slot B SHALL be loaded with 32'h0 for both operands and result B discarded.
REQ-022 REQ: mul_ready=1 exactly one cycle, mul_op = pair A; -> SEND_A.
REQ-023 SEND_A: mul_ready=0, mul_op = pair A (multiplier samples at end of this cycle); -> SEND_B.
REQ-024 SEND_B: mul_op = pair B (sampled at end of this cycle); -> WAIT, counter cleared.
REQ-025 WAIT: on mul_done=1 capture mul_res as result A; -> CAPB; else counter increments.
REQ-026 CAPB: capture mul_res as result B unconditionally (second done cycle); -> OUT.
REQ-027 mul_ready SHALL never assert in CAPB or before the cycle after CAPB.
REQ-028 OUT: out_valid=1, out_res = A then B; advance on out_valid&out_ready; odd tail emits A only.
REQ-029 out_last=1 only on last emitted result of a job whose final pair had in_last=1.
REQ-030 OUT -> IDLE after last result accepted; slots cleared; earliest next mul_ready two cycles after CAPB.
REQ-031 out_valid SHALL hold with stable out_res/out_last while out_ready=0.
REQ-032 mul_done outside WAIT SHALL be ignored.
REQ-033 WAIT counter reaching TIMEOUT with mul_done=0: timeout_err<=1, slots dropped, -> IDLE; no output emitted.
REQ-034 timeout_err cleared only by rst; operation continues after abort.
REQ-035 mul_op1/mul_op2 SHALL be registered; no combinational path from in_* to mul_*.

Reset
REQ-036 rst SHALL force IDLE, empty slots, counter 0.
REQ-037 Reset values: in_ready=1 (after rst release), out_valid=0, out_res=0, out_last=0, mul_ready=0, mul_op1=0, mul_op2=0, busy=0, timeout_err=0.
REQ-038 rst mid-job SHALL discard all buffered pairs and results; no output emitted for that job.

Verification
REQ-039 Pairs (0x40000000,0x40400000),(0x3FC00000,0x3FC00000), model done 5 cycles after SEND_B -> out_res 0x40C00000 then 0x40100000, out_last=0.
REQ-040 Single pair (0x40000000,0x40400000) with in_last=1 -> mul_op B = 0/0, one output 0x40C00000 with out_last=1.
REQ-041 out_ready=0 for 10 cycles in OUT -> out_valid held, out_res stable 0x40C00000, no second mul_ready.
REQ-042 Model never asserts done, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, IDLE, next job completes normally with flag still 1.
REQ-043 rst asserted in WAIT -> all outputs to reset values immediately; no out_valid afterwards.
REQ-044 Spurious mul_done pulse in IDLE and in OUT -> ignored; mul_ready spacing >=2 cycles after CAPB checked by assertion.

Source files
------------

// File: rtl/mul_pair_issuer.sv
// Pairs operands two at a time, issues them to a shared dual multiplier and
// streams the two products back out; an odd final pair is padded with zeros.
module mul_pair_issuer #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_op1,
   input  logic [31:0] in_op2,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_last,
   output logic        mul_ready,
   output logic [31:0] mul_op1,
   output logic [31:0] mul_op2,
   input  logic [31:0] mul_res,
   input  logic        mul_done,
   output logic        busy,
   output logic        timeout_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_SEND_A = 3'd2,
      S_SEND_B = 3'd3,
      S_WAIT   = 3'd4,
      S_CAPB   = 3'd5,
      S_OUT    = 3'd6
   } state_t;

   state_t        r_state;
   logic          r_has_a;
   logic [31:0]   r_a1, r_a2, r_b1, r_b2;
   logic          r_last;
   logic          r_odd;
   logic [31:0]   r_res_a, r_res_b;
   logic [TW-1:0] r_tcnt;
   logic          r_idx;
   logic          r_out_valid;
   logic [31:0]   r_out_res;
   logic          r_out_last;
   logic          r_mul_ready;
   logic [31:0]   r_mul_op1, r_mul_op2;
   logic          r_timeout_err;
   logic          w_accept;

   assign in_ready    = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign w_accept    = in_valid & in_ready;
   assign out_valid   = r_out_valid;
   assign out_res     = r_out_res;
   assign out_last    = r_out_last;
   assign mul_ready   = r_mul_ready;
   assign mul_op1     = r_mul_op1;
   assign mul_op2     = r_mul_op2;
   assign timeout_err = r_timeout_err;

   // Control FSM; every output is set on the transition into the state that owns it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_has_a       <= 1'b0;
         r_a1          <= 32'h0;
         r_a2          <= 32'h0;
         r_b1          <= 32'h0;
         r_b2          <= 32'h0;
         r_last        <= 1'b0;
         r_odd         <= 1'b0;
         r_res_a       <= 32'h0;
         r_res_b       <= 32'h0;
         r_tcnt        <= '0;
         r_idx         <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_res     <= 32'h0;
         r_out_last    <= 1'b0;
         r_mul_ready   <= 1'b0;
         r_mul_op1     <= 32'h0;
         r_mul_op2     <= 32'h0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && !r_has_a) begin
                  r_a1    <= in_op1;
                  r_a2    <= in_op2;
                  r_has_a <= 1'b1;
                  if (in_last) begin
                     // Odd tail: pad slot B so the multiplier still sees a full pair.
                     r_b1        <= 32'h0;
                     r_b2        <= 32'h0;
                     r_odd       <= 1'b1;
                     r_last      <= 1'b1;
                     r_mul_ready <= 1'b1;
                     r_mul_op1   <= in_op1;
                     r_mul_op2   <= in_op2;
                     r_state     <= S_REQ;
                  end
               end else if (w_accept) begin
                  r_b1        <= in_op1;
                  r_b2        <= in_op2;
                  r_odd       <= 1'b0;
                  r_last      <= in_last;
                  r_mul_ready <= 1'b1;
                  r_mul_op1   <= r_a1;
                  r_mul_op2   <= r_a2;
                  r_state     <= S_REQ;
               end
            end
            S_REQ: begin
               r_mul_ready <= 1'b0;
               r_state     <= S_SEND_A;
            end
            S_SEND_A: begin
               r_mul_op1 <= r_b1;
               r_mul_op2 <= r_b2;
               r_state   <= S_SEND_B;
            end
            S_SEND_B: begin
               r_tcnt  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_done) begin
                  r_res_a <= mul_res;
                  r_state <= S_CAPB;
               end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                  r_timeout_err <= 1'b1;
                  r_has_a       <= 1'b0;
                  r_a1          <= 32'h0;
                  r_a2          <= 32'h0;
                  r_b1          <= 32'h0;
                  r_b2          <= 32'h0;
                  r_state       <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            S_CAPB: begin
               r_res_b     <= mul_res;
               r_out_valid <= 1'b1;
               r_out_res   <= r_res_a;
               r_out_last  <= r_last & r_odd;
               r_idx       <= 1'b0;
               r_state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready && !r_idx && !r_odd) begin
                  r_out_res  <= r_res_b;
                  r_out_last <= r_last;
                  r_idx      <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_has_a     <= 1'b0;
                  r_a1        <= 32'h0;
                  r_a2        <= 32'h0;
                  r_b1        <= 32'h0;
                  r_b2        <= 32'h0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_pair_issuer.sv
// Randomised bench for mul_pair_issuer: a behavioural pairing model predicts every
// emitted product, and a dual-multiplier model answers the block's requests.
module tb_mul_pair_issuer;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_op1 = 32'h0;
   logic [31:0] in_op2 = 32'h0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_res;
   logic        out_last;
   logic        mul_ready;
   logic [31:0] mul_op1, mul_op2;
   logic [31:0] mul_res;
   logic        mul_done;
   logic        busy;
   logic        timeout_err;

   mul_pair_issuer #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_last(out_last),
      .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2),
      .mul_res(mul_res), .mul_done(mul_done), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in for the floating-point multiplier: exact for the pinned pairs.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
      return (a * b) ^ 32'h1234_5678;
   endfunction

   // ---------------- dual multiplier model ----------------
   int          ph = 0;
   int          cnt = 0;
   int          dly = 5;
   bit          rnd_dly = 1'b0;
   bit          never_done = 1'b0;
   logic [31:0] ma1 = 32'h0, ma2 = 32'h0, mb1 = 32'h0, mb2 = 32'h0;
   logic        m_done = 1'b0;
   logic [31:0] m_res = 32'h0;
   logic        spur = 1'b0;
   logic [31:0] spur_res = 32'hDEADBEEF;

   assign mul_done = m_done | spur;
   assign mul_res  = spur ? spur_res : m_res;

   always @(negedge clk) begin
      if (rst) begin
         ph     <= 0;
         m_done <= 1'b0;
      end else begin
         case (ph)
            0: if (mul_ready) ph <= 1;
            1: begin ma1 <= mul_op1; ma2 <= mul_op2; ph <= 2; end
            2: begin
               mb1 <= mul_op1; mb2 <= mul_op2;
               cnt <= rnd_dly ? int'($urandom_range(1, 8)) : dly;
               ph  <= 3;
            end
            3: begin
               if (!busy) ph <= 0;
               else if (!never_done) begin
                  if (cnt <= 1) begin m_done <= 1'b1; m_res <= fmul(ma1, ma2); ph <= 4; end
                  else cnt <= cnt - 1;
               end
            end
            4: begin
               chk("mul_ready_in_capb", {31'b0, mul_ready}, 32'd0);
               m_done <= 1'b1; m_res <= fmul(mb1, mb2); ph <= 5;
            end
            5: begin
               chk("mul_ready_after_capb", {31'b0, mul_ready}, 32'd0);
               m_done <= 1'b0; ph <= 0;
            end
            default: ph <= 0;
         endcase
      end
   end

   // ---------------- downstream ready driver ----------------
   int or_mode = 0;   // 0 always ready, 1 random, 2 stalled
   initial forever begin
      @(posedge clk);
      #2;
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
   end

   // ---------------- scoreboard and compare ----------------
   typedef struct {logic [31:0] res; logic last;} exp_t;
   exp_t        exp_q[$];
   logic [31:0] log_res[$];
   logic        log_last[$];
   exp_t        ce;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_res = 32'h0;
   logic        prev_last = 1'b0;

   always @(negedge clk) begin
      if (rst) prev_stall <= 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_res", out_res, prev_res);
            chk("hold_last", {31'b0, out_last}, {31'b0, prev_last});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            else begin
               ce = exp_q.pop_front();
               chk("out_res", out_res, ce.res);
               chk("out_last", {31'b0, out_last}, {31'b0, ce.last});
               log_res.push_back(out_res);
               log_last.push_back(out_last);
            end
         end
         prev_stall <= out_valid && !out_ready;
         prev_res   <= out_res;
         prev_last  <= out_last;
      end
   end

   // ---------------- pairing model + driver ----------------
   bit          pend_has = 1'b0;
   logic [31:0] pend_a1 = 32'h0, pend_a2 = 32'h0;

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last, input bit expect_out);
      int n = 0;
      in_op1 = a; in_op2 = b; in_last = last; in_valid = 1'b1;
      while (!in_ready && n < 500) begin @(negedge clk); n++; end
      if (!in_ready) begin
         chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (!pend_has) begin
         if (last) begin
            if (expect_out) exp_q.push_back('{fmul(a, b), 1'b1});
         end else begin
            pend_has = 1'b1; pend_a1 = a; pend_a2 = b;
         end
      end else begin
         pend_has = 1'b0;
         if (expect_out) begin
            exp_q.push_back('{fmul(pend_a1, pend_a2), 1'b0});
            exp_q.push_back('{fmul(a, b), last});
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy || out_valid) && n < 3000) begin @(negedge clk); n++; end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   function automatic logic [31:0] log_at(input int k);
      if (k < log_res.size()) return log_res[k];
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic last_at(input int k);
      if (k < log_last.size()) return log_last[k];
      return 1'bx;
   endfunction

   initial begin
      int base;
      int n;
      bit seen;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_res", out_res, 32'h0);
      chk("rst_out_last", {31'b0, out_last}, 32'd0);
      chk("rst_mul_ready", {31'b0, mul_ready}, 32'd0);
      chk("rst_mul_op1", mul_op1, 32'h0);
      chk("rst_mul_op2", mul_op2, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Two full pairs, done five cycles after SEND_B.
      base = log_res.size();
      send_pair(32'h40000000, 32'h40400000, 1'b0, 1'b1);
      send_pair(32'h3FC00000, 32'h3FC00000, 1'b0, 1'b1);
      drain();
      chk("pair_count", 32'(log_res.size() - base), 32'd2);
      chk("pair_res_a", log_at(base), 32'h40C00000);
      chk("pair_res_b", log_at(base + 1), 32'h40100000);
      chk("pair_last_b", {31'b0, last_at(base + 1)}, 32'd0);

      // Odd tail: single pair with in_last.
      base = log_res.size();
      send_pair(32'h40000000, 32'h40400000, 1'b1, 1'b1);
      drain();
      chk("odd_count", 32'(log_res.size() - base), 32'd1);
      chk("odd_res", log_at(base), 32'h40C00000);
      chk("odd_last", {31'b0, last_at(base)}, 32'd1);
      chk("odd_mul_op1_b", mb1, 32'h0);
      chk("odd_mul_op2_b", mb2, 32'h0);

      // Stall downstream in OUT, with a spurious done pulse while stalled.
      or_mode = 2;
      send_pair(32'h40000000, 32'h40400000, 1'b1, 1'b1);
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_res", out_res, 32'h40C00000);
         chk("stall_mul_ready", {31'b0, mul_ready}, 32'd0);
         spur = (i == 3);
         @(negedge clk);
      end
      spur = 1'b0;
      or_mode = 0;
      drain();

      // Spurious done pulse while idle.
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      chk("idle_spur_busy", {31'b0, busy}, 32'd0);
      chk("idle_spur_valid", {31'b0, out_valid}, 32'd0);

      // Multiplier never answers: abort after TIMEOUT wait cycles.
      never_done = 1'b1;
      send_pair(32'h11111111, 32'h22222222, 1'b1, 1'b0);
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      chk("timeout_busy_cycles", 32'(n), 32'd19);
      chk("timeout_err_set", {31'b0, timeout_err}, 32'd1);
      never_done = 1'b0;
      base = log_res.size();
      send_pair(32'h3FC00000, 32'h3FC00000, 1'b1, 1'b1);
      drain();
      chk("after_abort_res", log_at(base), 32'h40100000);
      chk("timeout_err_sticky", {31'b0, timeout_err}, 32'd1);

      // Reset in the middle of WAIT.
      dly = 40;
      send_pair(32'h40000000, 32'h40400000, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("mid_busy_before_rst", {31'b0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_mul_ready", {31'b0, mul_ready}, 32'd0);
      chk("midrst_mul_op1", mul_op1, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_timeout_err", {31'b0, timeout_err}, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      dly = 5;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("no_out_after_rst", {31'b0, seen}, 32'd0);

      // Randomised traffic with random multiplier latency and backpressure.
      or_mode = 1;
      rnd_dly = 1'b1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_pair($urandom, $urandom, 1'($urandom_range(0, 3) == 0), 1'b1);
      end
      if (pend_has) send_pair($urandom, $urandom, 1'b1, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
